pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, synchronous flush and back-pressure, used between any two CPU pipeline stages (IF/ID, ID/EX, EX/ME, ME/WB). Each stage's bundle is split into a control field, zeroed to form a bubble on reset, flush or drain, and a data payload. An optional skid buffer registers the upstream ready path for timing closure. A saturating stall counter supports performance analysis.

---
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, flush, bubble control.
// Define PIPE_SKID_EN for the 2-entry skid mode with registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic w_in_ready;
  logic w_in_xfer;
  logic w_stall;

  assign w_in_xfer = in_valid & w_in_ready;
  assign w_stall   = r_valid & ~out_ready;

`ifdef PIPE_SKID_EN

  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_main_free;

  // Ready depends only on skid state, so the upstream path is registered.
  assign w_in_ready  = ~rst & ~flush & ~r_skid_valid;
  assign w_main_free = ~r_valid | out_ready;

  // Main register: refill from skid first so older beats leave first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_valid <= 1'b1;
        r_ctrl  <= r_skid_ctrl;
        r_data  <= r_skid_data;
      end else if (w_in_xfer) begin
        r_valid <= 1'b1;
        r_ctrl  <= in_ctrl;
        r_data  <= in_data;
      end else begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end
    end
  end

  // Skid entry: catches the beat accepted while main is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
    end else if (w_main_free) begin
      r_skid_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= in_ctrl;
      r_skid_data  <= in_data;
    end
  end

`else

  logic w_out_xfer;

  assign w_out_xfer = r_valid & out_ready;
  assign w_in_ready = ~flush & (~r_valid | out_ready);

  // Single register: load on accept, bubble on drain or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_ctrl  <= in_ctrl;
      r_data  <= in_data;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end

`endif

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_ctrl  = r_ctrl;
  assign out_data  = r_data;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (default or PIPE_SKID_EN build).
// Model: queue of held beats, saturating stall count.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 128;
  localparam int NW = 4;
  localparam int SMAX = (1 << NW) - 1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  int    tests = 0;
  int    fails = 0;
  beat_t q[$];
  int    m_stall = 0;
  int    seq = 0;

  pipe_stage_reg #(
    .CTRL_W(CW),
    .DATA_W(DW),
    .CNT_W (NW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model, then retire beats.
  bit   m_v;
  logic m_rdy;
  always @(negedge clk) begin
    if (!rst) begin
      m_v = (q.size() > 0);
      chk("out_valid", DW'(out_valid), DW'(m_v));
      chk("out_ctrl", DW'(out_ctrl), m_v ? DW'(q[0].c) : '0);
      if (m_v) chk("out_data", out_data, q[0].d);
      if (SKID) m_rdy = !flush && (q.size() < 2);
      else m_rdy = !flush && (!m_v || out_ready);
      chk("in_ready", DW'(in_ready), DW'(m_rdy));
      chk("stall_cnt", DW'(stall_cnt), DW'(m_stall));
      if (m_v && !out_ready && m_stall < SMAX) m_stall++;
      if (flush) q.delete();
      else if (m_v && out_ready) q.delete(0);
    end
  end

  // One cycle: record an accepted beat as expected, then advance.
  task automatic step(output bit acc);
    @(negedge clk);
    #1;
    acc = !rst && !flush && in_valid && in_ready;
    if (acc) q.push_back(beat_t'{c: in_ctrl, d: in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit ordy, input bit fl,
                       output bit acc);
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    step(acc);
  endtask

  task automatic next_seq();
    seq++;
    in_ctrl = CW'(seq);
    in_data = DW'(seq);
  endtask

  task automatic next_rand();
    in_ctrl = CW'($urandom);
    in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic rand_run(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0,
            ($urandom % 20) == 0, acc);
      if (acc) next_rand();
    end
  endtask

  initial begin
    bit            acc;
    logic [DW-1:0] hold;

    // Reset state while rst is asserted.
    #1;
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_ctrl", DW'(out_ctrl), '0);
    chk("rst_data", out_data, '0);
    chk("rst_stall", DW'(stall_cnt), '0);
    chk("rst_in_ready", DW'(in_ready), DW'(!SKID));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, acc);
    chk("post_rst_ready", DW'(in_ready), DW'(1));

    // Stream 1..8 with out_ready held high.
    seq = 0;
    next_seq();
    for (int i = 0; i < 20 && seq <= 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, acc);
      if (acc) next_seq();
    end
    chk("stream_count", DW'(seq), DW'(9));
    chk("stream_stall", DW'(stall_cnt), '0);

    // Back-pressure for 5 cycles, then drain.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, acc);
      if (acc) next_seq();
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, acc);
    chk("bp_stall", DW'(stall_cnt), DW'(5));
    chk("bp_empty", DW'(out_valid), '0);

    // Drain: single beat then bubble, payload holds.
    in_ctrl = 8'hA5;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    hold    = in_data;
    drive(1'b1, 1'b1, 1'b0, acc);
    chk("drain_acc", DW'(acc), DW'(1));
    chk("drain_ctrl", DW'(out_ctrl), DW'(8'hA5));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, acc);
    chk("drain_valid", DW'(out_valid), '0);
    chk("drain_ctrl0", DW'(out_ctrl), '0);
    chk("drain_hold", out_data, hold);

    // Flush with beats held and in_valid high.
    next_rand();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, acc);
      if (acc) next_rand();
    end
    next_rand();
    drive(1'b1, 1'b0, 1'b1, acc);
    chk("flush_noacc", DW'(acc), '0);
    chk("flush_valid", DW'(out_valid), '0);
    chk("flush_ctrl", DW'(out_ctrl), '0);
    next_rand();
    hold = in_data;
    drive(1'b1, 1'b1, 1'b0, acc);
    chk("flush_next_acc", DW'(acc), DW'(1));
    chk("flush_first_v", DW'(out_valid), DW'(1));
    chk("flush_first_d", out_data, hold);
    drive(1'b0, 1'b1, 1'b0, acc);

    // Randomised traffic with occasional flush.
    next_rand();
    rand_run(400);

    // Saturation, unaffected by flush.
    next_rand();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, acc);
      if (acc) next_rand();
    end
    chk("sat_stall", DW'(stall_cnt), DW'(SMAX));
    drive(1'b0, 1'b0, 1'b1, acc);
    chk("sat_flush", DW'(stall_cnt), DW'(SMAX));

    // Async reset between edges with a beat held.
    next_rand();
    drive(1'b1, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    chk("ar_held", DW'(out_valid), DW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", DW'(out_valid), '0);
    chk("ar_ctrl", DW'(out_ctrl), '0);
    chk("ar_data", out_data, '0);
    chk("ar_stall", DW'(stall_cnt), '0);
    chk("ar_in_ready", DW'(in_ready), DW'(!SKID));
    q.delete();
    m_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, acc);
    chk("ar_ready_after", DW'(in_ready), DW'(1));

    next_rand();
    rand_run(100);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
